// File: rtl/sched_pkg.sv
// Shared definitions for the uop stream scheduler: uop field layout, the
// "no register" marker and the stream index type.
package sched_pkg;
  localparam int STORE_BIT = 13;
  localparam int DEST_LSB  = 8;
  localparam int DEST_W    = 4;
  localparam int SRC1_LSB  = 3;
  localparam int SRC0_LSB  = 0;
  localparam int SRC_W     = 3;

  localparam int                REG_W    = 4;
  localparam logic [REG_W-1:0]  REG_NONE = '1;

  localparam int MAX_STREAMS = 8;
  typedef logic [$clog2(MAX_STREAMS)-1:0] stream_idx_t;
endpackage

// File: rtl/uop_rr_pick.sv
// Rotating first-set finder: returns the first set bit of req scanning
// start, start+1, ... with an explicit wrap at N (N need not be a power of two).
module uop_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [IDX_W:0] s;

  assign dbl = {req, req} >> start;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        s     = {1'b0, start} + (IDX_W+1)'(k);
        if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
        idx   = s[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/uop_stream_scheduler.sv
// N-stream uop issue scheduler: main stream owns issue, independent alt uops are
// interleaved during memory ops or main bubbles. Optional SCHED_PERF_CNT_EN adds counters.
module uop_stream_scheduler
  import sched_pkg::*;
#(
  parameter  int NUM_STREAMS = 2,
  parameter  int UOP_W       = 20,
  parameter  int REG_IDX_W   = 4,
  localparam int SW          = $clog2(NUM_STREAMS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_STREAMS-1:0]       in_valid,
  input  logic [NUM_STREAMS*UOP_W-1:0] in_uop,
  input  logic [NUM_STREAMS-1:0]       in_last,
  output logic [NUM_STREAMS-1:0]       in_ready,
  input  logic                         ex_doing_mem,
  output logic                         issue_valid,
  output logic [UOP_W-1:0]             issue_uop,
  output logic [SW-1:0]                issue_stream,
  input  logic                         issue_ready,
  output logic [SW-1:0]                main_stream
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_interleaved
`endif
);
  localparam logic [REG_IDX_W-1:0] NONE_IDX = '1;

  logic [NUM_STREAMS-1:0][UOP_W-1:0]     uop;
  logic [NUM_STREAMS-1:0][REG_IDX_W-1:0] last_dest;
  logic [NUM_STREAMS-1:0]                last_store;
  logic [NUM_STREAMS-1:0]                alt_req;
  logic                                  alt_found;
  logic [SW-1:0]                         alt_idx;
  logic [SW-1:0]                         main_nxt;
  logic [SW-1:0]                         sel;
  logic                                  accept;
  logic                                  slot_free;

  assign uop       = in_uop;
  assign slot_free = ~issue_valid | issue_ready;
  assign main_nxt  = (main_stream == SW'(NUM_STREAMS-1)) ? '0 : main_stream + 1'b1;

  // A stream may slip in ahead of main only if it cannot depend on anything
  // another stream still has in flight.
  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_elig
    logic [REG_IDX_W-1:0] s0, s1;
    logic                 haz;
    assign s0 = REG_IDX_W'(uop[i][SRC0_LSB +: SRC_W]);
    assign s1 = REG_IDX_W'(uop[i][SRC1_LSB +: SRC_W]);
    always_comb begin
      haz = 1'b0;
      for (int j = 0; j < NUM_STREAMS; j++) begin
        if (j != i) begin
          if (last_store[j]) haz = 1'b1;
          if (last_dest[j] != NONE_IDX && (last_dest[j] == s0 || last_dest[j] == s1)) haz = 1'b1;
        end
      end
    end
    assign alt_req[i] = in_valid[i] & ~in_last[i] & ~uop[i][STORE_BIT] & ~haz
                      & (main_stream != SW'(i));
  end

  uop_rr_pick #(.N(NUM_STREAMS), .IDX_W(SW)) u_alt_pick (
    .req   (alt_req),
    .start (main_nxt),
    .found (alt_found),
    .idx   (alt_idx)
  );

  always_comb begin
    accept = 1'b0;
    sel    = main_stream;
    if (slot_free) begin
      if (ex_doing_mem && alt_found) begin
        accept = 1'b1;
        sel    = alt_idx;
      end else if (in_valid[main_stream]) begin
        accept = 1'b1;
        sel    = main_stream;
      end else if (alt_found) begin
        accept = 1'b1;
        sel    = alt_idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (accept && rst_n) in_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid  <= 1'b0;
      issue_uop    <= '0;
      issue_stream <= '0;
      main_stream  <= '0;
      last_dest    <= {NUM_STREAMS{NONE_IDX}};
      last_store   <= '0;
    end else if (accept) begin
      issue_valid       <= 1'b1;
      issue_uop         <= uop[sel];
      issue_stream      <= sel;
      last_dest[sel]    <= REG_IDX_W'(uop[sel][DEST_LSB +: DEST_W]);
      last_store[sel]   <= uop[sel][STORE_BIT];
      if (sel == main_stream && in_last[sel]) main_stream <= main_nxt;
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued      <= '0;
      perf_interleaved <= '0;
    end else if (accept) begin
      perf_issued <= perf_issued + 32'd1;
      if (sel != main_stream) perf_interleaved <= perf_interleaved + 32'd1;
    end
  end
`endif
endmodule
